// File: rtl/itlb_walker_pkg.sv
// itlb_pkg: PTE/VA field layout and walker state encoding shared by the ITLB and its walker.
//   PPN_MSB/PPN_LSB : physical page number field in a PTE
//   PTE_V           : valid bit position in a PTE
//   VPN1/VPN2/OFF   : virtual address split for the two-level walk
//   walk_state_t    : walker FSM states
//   pte_addr()      : word address of a PTE from a table PPN and an index
package itlb_pkg;
   localparam int PPN_MSB  = 31;
   localparam int PPN_LSB  = 12;
   localparam int PTE_V    = 0;
   localparam int VPN1_MSB = 31;
   localparam int VPN1_LSB = 22;
   localparam int VPN2_MSB = 21;
   localparam int VPN2_LSB = 12;
   localparam int OFF_MSB  = 11;
   localparam int OFF_LSB  = 0;
   typedef enum logic [2:0] {W_IDLE, W_L1, W_L2, W_RESP, W_HOLD} walk_state_t;
   function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [9:0] vpn);
      return {ppn, vpn, 2'b00};
   endfunction
endpackage

// File: rtl/itlb_walker_if.sv
// itlb_walker_if: bundle between the ITLB/memory side (master) and the page-table walker (slave).
//   req_i/vaddr_i/ptbr_i       : walk request from the ITLB miss state
//   mem_req_o/mem_addr_o       : PTE read request towards the bus arbiter
//   mem_ack_i/mem_rdata_i      : read completion and PTE data
//   paddr_o/valid_o/suc_o      : refill pulse back into the ITLB
//   busy_o                     : walker not idle
interface itlb_walker_if;
   logic        req_i;
   logic [31:0] vaddr_i;
   logic [19:0] ptbr_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] paddr_o;
   logic        valid_o;
   logic        suc_o;
   logic        busy_o;
   modport slave (
      input  req_i, vaddr_i, ptbr_i, mem_ack_i, mem_rdata_i,
      output mem_req_o, mem_addr_o, paddr_o, valid_o, suc_o, busy_o
   );
   modport master (
      output req_i, vaddr_i, ptbr_i, mem_ack_i, mem_rdata_i,
      input  mem_req_o, mem_addr_o, paddr_o, valid_o, suc_o, busy_o
   );
endinterface

// File: rtl/itlb_walker_timer.sv
// walk_timer: 8-bit access watchdog; clears on clr, counts on inc, flags the cycle the count would reach TIMEOUT.
//   clk, rst : clock, synchronous active-low reset
//   clr      : restart counting (entry to a memory access)
//   inc      : one more cycle without ack
//   expired  : this cycle is the TIMEOUT-th without ack
module walk_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 8'd1;
   end
   assign expired = inc && cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/itlb_walker.sv
// itlb_walker: two-level page-table walker servicing ITLB misses, returning one refill pulse per walk.
//   clk, rst : clock, synchronous active-low reset
//   bus      : itlb_walker_if.slave (request, PTE memory reads, refill response, busy)
//   TIMEOUT  : cycles to wait for mem_ack_i on one access before faulting (1..255)
module itlb_walker
   import itlb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input logic         clk,
   input logic         rst,
   itlb_walker_if.slave bus
);
   walk_state_t        state;
   logic [VPN2_MSB:0]  va;
   logic               abort_q;
   logic               in_walk;
   logic               clr;
   logic               inc;
   logic               expired;
   logic               abort;
   logic               pte_v;
   logic               unused_pte_bits;
   assign in_walk = state == W_L1 || state == W_L2;
   assign clr     = state == W_IDLE || (state == W_L1 && bus.mem_ack_i);
   assign inc     = in_walk && !bus.mem_ack_i;
   // A request dropped in this very cycle aborts just like one dropped earlier.
   assign abort   = abort_q || !bus.req_i;
   assign pte_v   = bus.mem_rdata_i[PTE_V];
   assign unused_pte_bits = ^bus.mem_rdata_i[PPN_LSB-1:PTE_V+1];
   walk_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .inc     (inc),
      .expired (expired)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= W_IDLE;
         va             <= '0;
         abort_q        <= 1'b0;
         bus.mem_req_o  <= 1'b0;
         bus.mem_addr_o <= '0;
         bus.paddr_o    <= '0;
         bus.valid_o    <= 1'b0;
         bus.suc_o      <= 1'b0;
         bus.busy_o     <= 1'b0;
      end else begin
         bus.valid_o <= 1'b0;
         unique case (state)
            W_IDLE: if (bus.req_i) begin
               state          <= W_L1;
               va             <= bus.vaddr_i[VPN2_MSB:0];
               abort_q        <= 1'b0;
               bus.mem_req_o  <= 1'b1;
               bus.mem_addr_o <= pte_addr(bus.ptbr_i, bus.vaddr_i[VPN1_MSB:VPN1_LSB]);
               bus.paddr_o    <= '0;
               bus.suc_o      <= 1'b0;
               bus.busy_o     <= 1'b1;
            end
            W_L1, W_L2: begin
               if (!bus.req_i) abort_q <= 1'b1;
               // A timed-out access is finished: any later ack lands in RESP/HOLD/IDLE and is ignored.
               if (bus.mem_ack_i || expired) begin
                  if (abort) begin
                     state         <= W_IDLE;
                     bus.mem_req_o <= 1'b0;
                     bus.busy_o    <= 1'b0;
                  end else if (bus.mem_ack_i && pte_v && state == W_L1) begin
                     state          <= W_L2;
                     bus.mem_addr_o <= pte_addr(bus.mem_rdata_i[PPN_MSB:PPN_LSB], va[VPN2_MSB:VPN2_LSB]);
                  end else begin
                     state         <= W_RESP;
                     bus.mem_req_o <= 1'b0;
                     bus.valid_o   <= 1'b1;
                     bus.suc_o     <= bus.mem_ack_i && pte_v;
                     bus.paddr_o   <= bus.mem_ack_i && pte_v ?
                                      {bus.mem_rdata_i[PPN_MSB:PPN_LSB], va[OFF_MSB:OFF_LSB]} : '0;
                  end
               end
            end
            W_RESP: state <= W_HOLD;
            W_HOLD: begin
               state      <= W_IDLE;
               bus.busy_o <= 1'b0;
            end
            default: state <= W_IDLE;
         endcase
      end
   end
endmodule
